alu_rr_arbiter: RTL
===================

# alu_rr_arbiter

Two-requester round-robin arbiter and sequencer for the shared 32-bit registered ALU (ops: 000 add, 001 and, 010 or, 011 mul, 100 sub, 101 set-less-than). It accepts one operation at a time through a valid/ready handshake. It holds the operands stable to the ALU, captures the registered result and zero flag, and returns them tagged with the requester id through a response handshake that supports backpressure. Illegal opcodes (110, 111) are rejected locally and never reach the ALU.

## Interface
- DATA_W, 32, operand/result width
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_b2_req_valid  in  2  per-requester request valid (bit n = requester n)
- o_b2_req_ready  out  2  per-requester accept; a request is taken when valid[n] & ready[n]
- i_ul_a0, i_ul_b0  in  DATA_W  requester 0 operands
- i_u3_sel0  in  3  requester 0 opcode
- i_ul_a1, i_ul_b1  in  DATA_W  requester 1 operands
- i_u3_sel1  in  3  requester 1 opcode
- o_ul_alu_a, o_ul_alu_b  out  DATA_W  operands driven to the ALU
- o_u3_alu_sel  out  3  opcode driven to the ALU
- i_ul_alu_r  in  DATA_W  ALU registered result
- i_bi_alu_zflag  in  1  ALU registered zero flag
- o_bi_rsp_valid  out  1  response valid
- i_bi_rsp_ready  in  1  response accept
- o_bi_rsp_id  out  1  requester that issued the operation
- o_ul_r  out  DATA_W  result
- o_bi_zflag  out  1  zero flag
- o_bi_err  out  1  illegal opcode

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE: the grant is combinational over i_b2_req_valid.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester selected by the priority pointer is granted.
  - o_b2_req_ready[g] = 1 for the granted requester only. Both ready bits are 0 in every other state.
- On accept, latch a, b, sel and id into operand registers, then flip the priority pointer to the other requester.
  - Legal sel: go to ISSUE.
  - sel 110/111: go to RESP with o_ul_r = 0, o_bi_zflag = 1, o_bi_err = 1. The ALU result is not used.
- ISSUE: the ALU samples the latched operands at the end of this cycle. Always go to WAIT.
- WAIT: i_ul_alu_r and i_bi_alu_zflag are valid. Capture them into the response registers with o_bi_err = 0, then go to RESP.
- RESP: o_bi_rsp_valid = 1 and the response registers are held stable. When i_bi_rsp_ready = 1, return to IDLE.
- The ALU ports are driven continuously from the operand registers. They change only on accept.
- The priority pointer advances only on accept, never while a requester is idle or stalled.

## Timing
- Accept in cycle T:
  - Legal op: o_bi_rsp_valid rises in T+3.
  - Illegal op: o_bi_rsp_valid rises in T+1.
- RESP and IDLE each last at least one cycle. With ready tied high, the maximum legal-op throughput is one operation per 4 cycles.
- The grant may depend on valid. Requesters must not make valid depend on ready.
- A response is held indefinitely while i_bi_rsp_ready = 0.
- Reset values: state IDLE, pointer 0, o_b2_req_ready 0, o_bi_rsp_valid 0, o_bi_rsp_id 0, o_ul_r 0, o_bi_zflag 0, o_bi_err 0, ALU operand/sel outputs 0.
- Reset mid-operation, in any state: the operation is aborted and no response is produced. Any later ALU output is ignored.
- The ALU has no reset. Its first-cycle output after reset is never captured, because the block cannot reach WAIT within two cycles of reset release.

## Structure
- Shared package (alu_pkg):
  - opcode constants OP_ADD=000, OP_AND=001, OP_OR=010, OP_MUL=011, OP_SUB=100, OP_SLT=101
  - state encoding
  - an is_legal_op function (sel ≤ 101)
- Natural sub-module: rr_arb2. It is combinational, takes the 2 valid bits and the pointer, and produces a one-hot grant. The pointer register lives in the parent.
- The ALU is instantiated beside this block at top level, not inside it.

## Test plan
- Single op: requester 0 sends add a=5, b=7 → ready0 in the accept cycle; 3 cycles later rsp_valid with r=12, zflag=0, id=0, err=0.
- Contention and fairness: both requesters valid continuously, requester 0 sub 9−9, requester 1 mul 3×4, rsp_ready=1 → grants alternate 0,1,0,1; responses are r=0/zflag=1/id=0, then r=12/zflag=0/id=1.
- Illegal opcode: requester 1 sel=111 → rsp_valid one cycle after accept, r=0, zflag=1, err=1, id=1. The ALU operand ports change but no capture occurs.
- Backpressure: slt a=2, b=3 with rsp_ready held 0 for 5 cycles → rsp_valid, r=1, and id stay stable for 5 cycles; both ready bits stay 0; one cycle after rsp_ready rises, return to IDLE.
- Reset mid-op: assert rst during WAIT → all outputs go to reset values immediately (asynchronously); after release no response appears, and the next request from requester 0 (pointer=0) is granted normally.
- Pointer hold: requester 1 alone sends two ops back-to-back, then both requesters become valid → requester 0 is granted first (the pointer flipped to 0 after requester 1's last accept).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU front-end: opcodes, sequencer states and
// the opcode legality check.
package alu_pkg;

    localparam int ALU_DATA_W = 32;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    function automatic logic is_legal_op(input logic [2:0] sel);
        return sel <= OP_SLT;
    endfunction

endpackage

// File: rtl/alu_rr_arbiter_if.sv
// Signal bundle between two ALU requesters, the arbiter/sequencer and the
// shared registered ALU; master is the requester/response-sink side.
interface alu_rr_arbiter_if #(parameter int DATA_W = 32);

    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [DATA_W-1:0] a0, b0, a1, b1;
    logic [2:0]        sel0, sel1;

    logic [DATA_W-1:0] alu_a, alu_b, alu_r;
    logic [2:0]        alu_sel;
    logic              alu_zflag;

    logic              rsp_valid, rsp_ready, rsp_id;
    logic [DATA_W-1:0] r;
    logic              zflag, err;

    modport master (
        output req_valid, a0, b0, sel0, a1, b1, sel1, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, r, zflag, err
    );

    modport slave (
        input  req_valid, a0, b0, sel0, a1, b1, sel1, rsp_ready, alu_r, alu_zflag,
        output req_ready, rsp_valid, rsp_id, r, zflag, err, alu_a, alu_b, alu_sel
    );

endinterface

// File: rtl/alu_rr_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to
// the requester named by the priority pointer. Purely combinational.
module rr_arb2 (
    input  logic [1:0] i_b2_valid,
    input  logic       i_bi_ptr,
    output logic [1:0] o_b2_grant
);

    always_comb begin
        // NOTE: assign a default before the case so no path leaves the output unassigned (no latch).
        o_b2_grant = 2'b00;
        case (i_b2_valid)
            2'b01:   o_b2_grant = 2'b01;
            2'b10:   o_b2_grant = 2'b10;
            2'b11:   o_b2_grant = i_bi_ptr ? 2'b10 : 2'b01;
            default: o_b2_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin front-end for the shared registered ALU: accepts one op at a
// time, holds operands, captures the result and returns it tagged by requester.
module alu_rr_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        i_b2_req_valid,
    output logic [1:0]        o_b2_req_ready,
    input  logic [DATA_W-1:0] i_ul_a0,
    input  logic [DATA_W-1:0] i_ul_b0,
    input  logic [2:0]        i_u3_sel0,
    input  logic [DATA_W-1:0] i_ul_a1,
    input  logic [DATA_W-1:0] i_ul_b1,
    input  logic [2:0]        i_u3_sel1,
    output logic [DATA_W-1:0] o_ul_alu_a,
    output logic [DATA_W-1:0] o_ul_alu_b,
    output logic [2:0]        o_u3_alu_sel,
    input  logic [DATA_W-1:0] i_ul_alu_r,
    input  logic              i_bi_alu_zflag,
    output logic              o_bi_rsp_valid,
    input  logic              i_bi_rsp_ready,
    output logic              o_bi_rsp_id,
    output logic [DATA_W-1:0] o_ul_r,
    output logic              o_bi_zflag,
    output logic              o_bi_err
);

    state_t            r_state;
    logic              r_ptr;
    logic [DATA_W-1:0] r_op_a, r_op_b;
    logic [2:0]        r_op_sel;
    logic              r_op_id;
    logic [DATA_W-1:0] r_rsp_r;
    logic              r_rsp_z, r_rsp_err, r_rsp_id;

    logic [1:0]        w_b2_grant;
    logic              w_accept, w_id;
    logic [DATA_W-1:0] w_a, w_b;
    logic [2:0]        w_sel;

    rr_arb2 u_rr_arb2 (
        .i_b2_valid (i_b2_req_valid),
        .i_bi_ptr   (r_ptr),
        .o_b2_grant (w_b2_grant)
    );

    // Ready is gated by rst so it reads 0 while reset is held, even with valid high.
    assign o_b2_req_ready = (r_state == ST_IDLE && !rst) ? w_b2_grant : 2'b00;
    assign w_accept       = |o_b2_req_ready;
    assign w_id           = w_b2_grant[1];
    assign w_a            = w_id ? i_ul_a1   : i_ul_a0;
    assign w_b            = w_id ? i_ul_b1   : i_ul_b0;
    assign w_sel          = w_id ? i_u3_sel1 : i_u3_sel0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= 1'b0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_op_sel  <= '0;
            r_op_id   <= 1'b0;
            r_rsp_r   <= '0;
            r_rsp_z   <= 1'b0;
            r_rsp_err <= 1'b0;
            r_rsp_id  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op_a   <= w_a;
                        r_op_b   <= w_b;
                        r_op_sel <= w_sel;
                        r_op_id  <= w_id;
                        r_ptr    <= ~w_id;
                        if (is_legal_op(w_sel)) begin
                            r_state <= ST_ISSUE;
                        end else begin
                            // Illegal op answers locally; whatever the ALU computes is ignored.
                            r_rsp_r   <= '0;
                            r_rsp_z   <= 1'b1;
                            r_rsp_err <= 1'b1;
                            r_rsp_id  <= w_id;
                            r_state   <= ST_RESP;
                        end
                    end
                end
                ST_ISSUE: r_state <= ST_WAIT;
                ST_WAIT: begin
                    r_rsp_r   <= i_ul_alu_r;
                    r_rsp_z   <= i_bi_alu_zflag;
                    r_rsp_err <= 1'b0;
                    r_rsp_id  <= r_op_id;
                    r_state   <= ST_RESP;
                end
                ST_RESP: begin
                    if (i_bi_rsp_ready) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_ul_alu_a     = r_op_a;
    assign o_ul_alu_b     = r_op_b;
    assign o_u3_alu_sel   = r_op_sel;
    assign o_bi_rsp_valid = (r_state == ST_RESP);
    assign o_bi_rsp_id    = r_rsp_id;
    assign o_ul_r         = r_rsp_r;
    assign o_bi_zflag     = r_rsp_z;
    assign o_bi_err       = r_rsp_err;

endmodule
